// File: rtl/riscvooo_muldiv_arbiter_pkg.sv
// riscvooo_muldiv_arbiter_pkg: MulDiv request/response widths, fn codes and fn-field position
package riscvooo_muldiv_arbiter_pkg;
  localparam int REQ_W  = 67;
  localparam int RESP_W = 64;
  localparam int FN_MSB = 66;
  localparam int FN_LSB = 64;
  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;
  typedef enum logic {ID_REQ0 = 1'b0, ID_REQ1 = 1'b1} req_id_e;
endpackage

// File: rtl/riscvooo_muldiv_tag_fifo.sv
// riscvooo_muldiv_tag_fifo: 1-bit requester-ID FIFO, wrap-bit pointers
// Ports: push_i/id_i write an ID, pop_i drops the head; full_o, empty_o,
// head_o (oldest ID) and count_o (entries held) describe the contents.
module riscvooo_muldiv_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             id_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             head_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int AW = CNT_W - 1;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [CNT_W-1:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    count_o = wr_q - rd_q;
    empty_o = wr_q == rd_q;
    full_o  = count_o == CNT_W'(DEPTH);
    head_o  = mem_q[rd_q[AW-1:0]];
    wr_d    = wr_q + CNT_W'(push_i);
    rd_d    = rd_q + CNT_W'(pop_i);
    mem_d   = mem_q;
    if (push_i) mem_d[wr_q[AW-1:0]] = id_i;
  end
  always_ff @(posedge clk) begin
    wr_q  <= reset ? '0 : wr_d;
    rd_q  <= reset ? '0 : rd_d;
    mem_q <= mem_d;
  end
endmodule

// File: rtl/riscvooo_muldiv_arbiter.sv
// riscvooo_muldiv_arbiter: round-robin share of one in-order MulDiv unit between two requesters
// Ports: reqN_* request handshakes in, respN_* response handshakes out,
// muldivreq_*/muldivresp_* to/from the unit, outstanding = ops in flight.
module riscvooo_muldiv_arbiter
  import riscvooo_muldiv_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_W-1:0]  req0_msg,
  input  logic              req0_val,
  output logic              req0_rdy,
  input  logic [REQ_W-1:0]  req1_msg,
  input  logic              req1_val,
  output logic              req1_rdy,
  output logic [RESP_W-1:0] resp0_msg,
  output logic              resp0_val,
  input  logic              resp0_rdy,
  output logic [RESP_W-1:0] resp1_msg,
  output logic              resp1_val,
  input  logic              resp1_rdy,
  output logic [REQ_W-1:0]  muldivreq_msg,
  output logic              muldivreq_val,
  input  logic              muldivreq_rdy,
  input  logic [RESP_W-1:0] muldivresp_msg,
  input  logic              muldivresp_val,
  output logic              muldivresp_rdy,
  output logic [CNT_W-1:0]  outstanding
);
  logic ptr_q, ptr_d, full, empty, head, grant1, any_val, base_rdy, fire, pop;
  riscvooo_muldiv_tag_fifo #(.DEPTH(TAG_DEPTH), .CNT_W(CNT_W)) u_tags (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fire),
    .id_i    (grant1),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .count_o (outstanding)
  );
  // Each rdy only looks at the other requester's val, so rdy never depends on its own val.
  always_comb begin
    any_val        = req0_val | req1_val;
    grant1         = (req0_val ^ req1_val) ? req1_val : ptr_q;
    base_rdy       = !reset & muldivreq_rdy & !full;
    req0_rdy       = base_rdy & !(ptr_q & req1_val);
    req1_rdy       = base_rdy & (ptr_q | !req0_val);
    muldivreq_val  = !reset & any_val & !full;
    muldivreq_msg  = !any_val ? '0 : grant1 ? req1_msg : req0_msg;
    fire           = muldivreq_val & muldivreq_rdy;
    ptr_d          = fire ? !grant1 : ptr_q;
    resp0_val      = !reset & muldivresp_val & !empty & !head;
    resp1_val      = !reset & muldivresp_val & !empty & head;
    muldivresp_rdy = !reset & !empty & (head ? resp1_rdy : resp0_rdy);
    pop            = muldivresp_val & muldivresp_rdy;
    resp0_msg      = muldivresp_msg;
    resp1_msg      = muldivresp_msg;
  end
  always_ff @(posedge clk) begin
    ptr_q <= reset ? 1'b0 : ptr_d;
    assert (reset || !(muldivresp_val && empty))
      else $error("muldiv_arbiter: muldivresp_val with no tag in flight");
  end
endmodule

// File: tb/tb_riscvooo_muldiv_arbiter.sv
module tb_riscvooo_muldiv_arbiter;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  logic clk = 1'b0, reset = 1'b1;
  logic [66:0] req0_msg, req1_msg, muldivreq_msg;
  logic        req0_val, req0_rdy, req1_val, req1_rdy;
  logic [63:0] resp0_msg, resp1_msg, muldivresp_msg;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic        muldivreq_val, muldivreq_rdy, muldivresp_val, muldivresp_rdy;
  logic [CW-1:0] outstanding;
  riscvooo_muldiv_arbiter #(.TAG_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
    .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .muldivreq_msg(muldivreq_msg), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
    .muldivresp_msg(muldivresp_msg), .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
    .outstanding(outstanding)
  );
  always #5 clk = ~clk;
  typedef struct {logic [63:0] res; int t;} uop_t;
  logic [66:0] src_q[2][$];
  logic [63:0] exp_q[2][$];
  logic [63:0] rx_q[2][$];
  uop_t unit_q[$];
  bit id_q[$];
  bit gnt_log[$];
  bit hold[2];
  bit ptr;
  int cnt, cyc, last_t;
  int p_val = 100, p_urdy = 100, p_srdy = 100, lat_lo = 1, lat_hi = 3;
  int n_tests, n_fail;

  task automatic chk(input string tag, input logic [66:0] got, input logic [66:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [66:0] m);
    logic [31:0] a, b;
    logic signed [63:0] p;
    a = m[63:32];
    b = m[31:0];
    case (m[66:64])
      3'd0: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      3'd1, 3'd3: return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      default: return {a % b, a / b};
    endcase
  endfunction

  function automatic logic [66:0] rand_msg();
    logic [2:0] fn;
    logic [31:0] a, b;
    fn = 3'($urandom_range(4));
    a = $urandom;
    b = $urandom;
    if ($urandom_range(3) == 0) b = 32'($urandom_range(255));
    if (b == 0) b = 1;
    if (a == 32'h8000_0000 && b == 32'hffff_ffff) b = 1;
    return {fn, a, b};
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
      rx_q[k].delete();
      hold[k] = 0;
    end
    unit_q.delete();
    id_q.delete();
    gnt_log.delete();
    cnt = 0;
    ptr = 0;
    last_t = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; req0_val = 1; req1_val = 1; muldivreq_rdy = 1;
    muldivresp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
    #1 chk("reset_outs", {req0_rdy, req1_rdy, muldivreq_val, muldivresp_rdy, resp0_val, resp1_val}, 0);
    @(posedge clk);
    #1;
    reset = 0; req0_val = 0; req1_val = 0; muldivresp_val = 0;
    chk("reset_outstanding", outstanding, 0);
    clear_model();
  endtask

  task automatic step();
    logic [66:0] m0, m1;
    logic v0, v1, ur, s0, s1, mv, full, any, g, hd, emr;
    logic [63:0] got;
    uop_t u;
    @(negedge clk);
    cyc++;
    v0 = src_q[0].size() > 0 && $urandom_range(99) < p_val;
    v1 = src_q[1].size() > 0 && $urandom_range(99) < p_val;
    m0 = v0 ? src_q[0][0] : rand_msg();
    m1 = v1 ? src_q[1][0] : rand_msg();
    ur = $urandom_range(99) < p_urdy;
    mv = unit_q.size() > 0 && unit_q[0].t <= cyc;
    s0 = !hold[0] && $urandom_range(99) < p_srdy;
    s1 = !hold[1] && $urandom_range(99) < p_srdy;
    req0_val = v0; req0_msg = m0; req1_val = v1; req1_msg = m1;
    muldivreq_rdy = ur; muldivresp_val = mv;
    muldivresp_msg = mv ? unit_q[0].res : {$urandom, $urandom};
    resp0_rdy = s0; resp1_rdy = s1;
    #1;
    full = cnt == DEPTH;
    any = v0 | v1;
    g = (v0 && v1) ? ptr : v1;
    hd = id_q.size() > 0 ? id_q[0] : 1'b0;
    emr = id_q.size() > 0 && (hd ? s1 : s0);
    chk("mreq_val", muldivreq_val, any && !full);
    if (v0) chk("req0_rdy", req0_rdy, !g && ur && !full);
    if (v1) chk("req1_rdy", req1_rdy, g && ur && !full);
    chk("mreq_msg", muldivreq_msg, !any ? 67'd0 : (g ? m1 : m0));
    chk("resp0_val", resp0_val, mv && !hd);
    chk("resp1_val", resp1_val, mv && hd);
    chk("mresp_rdy", muldivresp_rdy, emr);
    chk("resp0_bcast", resp0_msg, muldivresp_msg);
    chk("outstanding", outstanding, cnt);
    if (mv && emr) begin
      got = hd ? resp1_msg : resp0_msg;
      if (exp_q[hd].size() > 0) chk(hd ? "resp1_msg" : "resp0_msg", got, exp_q[hd].pop_front());
      rx_q[hd].push_back(got);
      void'(unit_q.pop_front());
      void'(id_q.pop_front());
      cnt--;
    end
    if (any && !full && ur) begin
      exp_q[g].push_back(ref_op(g ? m1 : m0));
      u.res = ref_op(muldivreq_msg);
      u.t = cyc + $urandom_range(lat_hi, lat_lo);
      if (u.t < last_t) u.t = last_t;
      last_t = u.t;
      unit_q.push_back(u);
      void'(src_q[g].pop_front());
      id_q.push_back(g);
      gnt_log.push_back(g);
      ptr = !g;
      cnt++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    hold[0] = 0;
    hold[1] = 0;
    while ((src_q[0].size() + src_q[1].size() + id_q.size()) > 0 && n < 10000) begin
      step();
      n++;
    end
    chk("drain_left", src_q[0].size() + src_q[1].size() + id_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1;
    req0_msg = '0; req1_msg = '0; muldivresp_msg = '0;
    req0_val = 0; req1_val = 0; muldivreq_rdy = 0;
    muldivresp_val = 0; resp0_rdy = 0; resp1_rdy = 0;
    do_reset();
    // req0 only, two multiplies
    src_q[0].push_back({3'd0, 32'd8, 32'd3});
    src_q[0].push_back({3'd0, 32'hffff_fff8, 32'd8});
    drain();
    chk("t1_rx0_cnt", rx_q[0].size(), 2);
    if (rx_q[0].size() == 2) begin
      chk("t1_mul_a", rx_q[0][0], 64'h18);
      chk("t1_mul_b", rx_q[0][1], 64'hffff_ffff_ffff_ffc0);
    end
    chk("t1_rx1_none", rx_q[1].size(), 0);
    src_q[1].push_back({3'd3, 32'hdead_beef, 32'h0000_beef});
    drain();
    chk("t1_rem_cnt", rx_q[1].size(), 1);
    if (rx_q[1].size() == 1) chk("t1_rem", rx_q[1][0], 64'hffff_da72_ffff_d353);
    // both valid every cycle: alternating grants from req0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_q[0].push_back({3'd0, 32'd5, 32'd7});
      src_q[1].push_back({3'd1, 32'h222, 32'h2a});
    end
    drain();
    chk("t2_gnt_cnt", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("t2_gnt", gnt_log[i], i % 2);
    chk("t2_rx1_cnt", rx_q[1].size(), 4);
    foreach (rx_q[1][i]) chk("t2_div", rx_q[1][i], 64'hd);
    // stalled head blocks the other requester
    do_reset();
    hold[0] = 1;
    src_q[0].push_back({3'd1, 32'd100, 32'd7});
    src_q[1].push_back({3'd0, 32'd1, 32'd1});
    r1 = 0;
    repeat (20) begin
      step();
      r1 += int'(resp1_val);
    end
    chk("t3_resp1_blocked", r1, 0);
    chk("t3_rx1_none", rx_q[1].size(), 0);
    drain();
    if (rx_q[0].size() > 0) chk("t3_div", rx_q[0][0], 64'h0000_0002_0000_000e);
    if (rx_q[1].size() > 0) chk("t3_mul", rx_q[1][0], 64'h1);
    chk("t3_cnt", rx_q[0].size() + rx_q[1].size(), 2);
    // fill to TAG_DEPTH with stalled sinks
    do_reset();
    hold[0] = 1;
    hold[1] = 1;
    for (int i = 0; i < 3; i++) begin
      src_q[0].push_back(rand_msg());
      src_q[1].push_back(rand_msg());
    end
    repeat (15) step();
    @(posedge clk);
    #1;
    chk("t4_full_outstanding", outstanding, DEPTH);
    chk("t4_rdy_low", {req0_rdy, req1_rdy}, 0);
    drain();
    // reset with ops in flight
    do_reset();
    hold[0] = 1;
    hold[1] = 1;
    src_q[0].push_back(rand_msg());
    src_q[0].push_back(rand_msg());
    repeat (6) step();
    chk("t5_inflight", cnt, 2);
    do_reset();
    src_q[0].push_back(rand_msg());
    src_q[1].push_back(rand_msg());
    step();
    chk("t5_first_grant_req0", gnt_log.size() > 0 ? gnt_log[0] : 1'b1, 0);
    drain();
    // random traffic, mixed fns and delays
    lat_lo = 1;
    lat_hi = 6;
    for (int blk = 0; blk < 15; blk++) begin
      if (blk == 7) do_reset();
      p_val  = $urandom_range(100, 30);
      p_urdy = $urandom_range(100, 30);
      p_srdy = $urandom_range(100, 20);
      hold[0] = $urandom_range(3) == 0;
      hold[1] = $urandom_range(3) == 0;
      repeat (200) begin
        for (int k = 0; k < 2; k++)
          if (src_q[k].size() < 3 && $urandom_range(1) == 1) src_q[k].push_back(rand_msg());
        step();
      end
    end
    p_val = 100; p_urdy = 100; p_srdy = 100;
    drain();
    chk("rand_exp_left", exp_q[0].size() + exp_q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
